// File: rtl/uart_sched_pkg.sv
// Shared types and width helpers for the USART TX packet scheduler.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  localparam int BYTE_W = 8;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin pick: first set request strictly after the pointer, wrapping around.
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         grant_o,
  output logic [$clog2(N_REQ)-1:0] id_o
);

  localparam int ID_W = $clog2(N_REQ);

  logic [2*N_REQ-1:0] req2_s;
  logic [2*N_REQ-1:0] masked_s;
  logic               found_s;

  // Duplicate the request vector so the search past the pointer never wraps.
  always_comb begin
    req2_s   = {req_i, req_i};
    masked_s = '0;
    grant_o  = '0;
    id_o     = '0;
    found_s  = 1'b0;
    for (int b = 0; b < 2*N_REQ; b++) begin
      masked_s[b] = req2_s[b] & (b > int'(ptr_i));
    end
    for (int b = 0; b < 2*N_REQ; b++) begin
      if (!found_s && masked_s[b]) begin
        found_s = 1'b1;
        if (b >= N_REQ) begin
          grant_o[b-N_REQ] = 1'b1;
          id_o             = ID_W'(b - N_REQ);
        end else begin
          grant_o[b] = 1'b1;
          id_o       = ID_W'(b);
        end
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one USART TX byte port between N_REQ requesters, one packet per grant,
// with an idle gap, a per-grant byte cap and a stall timeout.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 16,
  parameter int MAX_BURST  = 64,
  parameter int TIMEOUT    = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [BYTE_W*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      tx_valid,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int  ID_W       = $clog2(N_REQ);
  localparam int  BC_W       = cnt_w(MAX_BURST);
  localparam int  ST_W       = cnt_w(TIMEOUT);
  localparam int  GP_W       = cnt_w(GAP_CYCLES);
  localparam bit  HAS_BURST  = (MAX_BURST > 0);
  localparam bit  HAS_TMO    = (TIMEOUT > 0);
  localparam int  BURST_LAST = HAS_BURST ? MAX_BURST - 1 : 0;
  localparam int  STALL_LAST = HAS_TMO ? TIMEOUT - 1 : 0;
  localparam int  GAP_LAST   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              tmo_q, tmo_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [ST_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [GP_W-1:0]   gap_cnt_q, gap_cnt_d;

  logic [N_REQ-1:0]  arb_grant_s;
  logic [ID_W-1:0]   arb_id_s;
  logic              any_req_s;
  logic              in_xfer_s;
  logic              sel_valid_s;
  logic              sel_last_s;
  logic [BYTE_W-1:0] sel_data_s;
  logic              fire_s;
  logic              burst_hit_s;
  logic              stall_hit_s;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant_s),
    .id_o    (arb_id_s)
  );

  // Zero-latency passthrough between the grantee and the USART while in XFER.
  always_comb begin
    in_xfer_s   = (state_q == S_XFER);
    sel_valid_s = req_valid[grant_id_q];
    sel_last_s  = req_last[grant_id_q];
    sel_data_s  = req_data[BYTE_W*int'(grant_id_q) +: BYTE_W];
    req_ready   = '0;
    if (in_xfer_s) begin
      tx_valid              = sel_valid_s;
      tx_data               = sel_data_s;
      req_ready[grant_id_q] = tx_ready;
    end else begin
      tx_valid = 1'b0;
      tx_data  = '0;
    end
  end

  // Release conditions; a stall only counts while the grantee has nothing offered.
  always_comb begin
    any_req_s   = |arb_grant_s;
    fire_s      = tx_valid & tx_ready;
    burst_hit_s = HAS_BURST && (byte_cnt_q == BC_W'(BURST_LAST));
    stall_hit_s = HAS_TMO && !sel_valid_s && (stall_cnt_q == ST_W'(STALL_LAST));
  end

  // Next-state, counters and release bookkeeping.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    ptr_d       = ptr_q;
    busy_d      = busy_q;
    tmo_d       = 1'b0;
    byte_cnt_d  = byte_cnt_q;
    stall_cnt_d = stall_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (any_req_s) begin
          state_d     = S_XFER;
          grant_id_d  = arb_id_s;
          busy_d      = 1'b1;
          byte_cnt_d  = '0;
          stall_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_XFER: begin
        if ((fire_s && (sel_last_s || burst_hit_s)) || stall_hit_s) begin
          state_d     = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          busy_d      = 1'b0;
          ptr_d       = grant_id_q;
          tmo_d       = stall_hit_s;
          byte_cnt_d  = '0;
          stall_cnt_d = '0;
          gap_cnt_d   = '0;
        end else if (fire_s) begin
          byte_cnt_d  = HAS_BURST ? byte_cnt_q + BC_W'(1) : '0;
          stall_cnt_d = '0;
        end else if (sel_valid_s || !HAS_TMO) begin
          stall_cnt_d = '0;
        end else begin
          stall_cnt_d = stall_cnt_q + ST_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GP_W'(GAP_LAST)) begin
          state_d   = S_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and counter registers; pointer resets so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_id_q  <= '0;
      ptr_q       <= ID_W'(N_REQ - 1);
      busy_q      <= 1'b0;
      tmo_q       <= 1'b0;
      byte_cnt_q  <= '0;
      stall_cnt_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      tmo_q       <= tmo_d;
      byte_cnt_q  <= byte_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign timeout_err = tmo_q;

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Packet scheduler that shares the single USART1 transmitter between several on-chip requesters, such as the CPU console, a debug/trace unit and a DMA channel.
- Grants the transmitter to one requester per packet using round-robin order and holds the grant until that packet's last byte.
- Enforces an inter-packet idle gap, a per-grant byte limit and a stall timeout so that one requester cannot starve the others.
- Sits between the requesters and the USART TX byte interface (valid/ready) inside the cyber SoC.

Parameters:
N_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 16, idle clk cycles after each release before re-arbitration; 0 = no gap
MAX_BURST, 64, maximum bytes per grant; 0 = unlimited
TIMEOUT, 1024, consecutive cycles without req_valid from the granted requester before forced release; 0 = disabled

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  N_REQ  per-requester byte valid
req_data  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  input  N_REQ  byte is the last byte of the packet
req_ready  output  N_REQ  byte accepted (one-hot or zero)
tx_valid  output  1  byte valid to USART TX
tx_data  output  8  byte to USART TX
tx_ready  input  1  USART TX accepts the byte
grant_id  output  $clog2(N_REQ)  current or most recent grantee
busy  output  1  grant held (XFER state)
timeout_err  output  1  one-cycle pulse on forced release by timeout

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0; state IDLE; rr pointer = N_REQ-1, so requester 0 has first priority; all counters 0. Asserting reset mid-packet abandons the packet with no further handshake.
- A transfer occurs when tx_valid && tx_ready. The USART-side handshake rules are identical to standard valid/ready.
- IDLE:
  - If any req_valid is set, the rr_arbiter selects the first requester set at or after pointer+1 (cyclic). grant_id is registered and the state moves to XFER.
  - Requests are sampled at cycle t; grant_id/busy are valid at t+1; the earliest tx_valid is at t+1.
  - With no requests, the block stays in IDLE.
- XFER, with g = grant_id:
  - tx_valid = req_valid[g]; tx_data = requester g's byte; req_ready[g] = tx_ready. These are combinational passthrough, with zero added latency per byte.
  - req_ready of every other requester is 0.
  - The byte counter increments on each transfer.
  - Release occurs on a transfer with req_last[g] set, OR on a transfer that makes byte count == MAX_BURST (MAX_BURST != 0).
  - Release occurs on the stall counter reaching TIMEOUT. The stall counter counts cycles with req_valid[g]==0 and clears whenever req_valid[g]==1.
  - If last and MAX_BURST are reached on the same transfer, there is a single release with no error.
  - A timeout is never raised while req_valid[g]==1 and tx_ready==0; backpressure from the USART is not a stall.
- Release actions:
  - busy goes to 0 on the next cycle and the pointer is set to g.
  - On timeout release, timeout_err pulses for one cycle.
  - The next state is GAP if GAP_CYCLES>0, else IDLE.
  - The released requester's remaining bytes wait for a later grant.
- GAP:
  - tx_valid = 0, all req_ready = 0.
  - The gap counter counts GAP_CYCLES cycles, then the state returns to IDLE.
  - Requests arriving during GAP are held off and do not affect the count.
- grant_id holds the last grantee through GAP/IDLE until the next grant.
- Counter widths: byte counter $clog2(MAX_BURST+1); stall counter $clog2(TIMEOUT+1); gap counter $clog2(GAP_CYCLES+1). No wrap-around is permitted; each counter saturates at its limit and triggers the transition.
- Requester protocol error: req_valid dropping mid-byte (before ready) is tolerated. The block only counts completed transfers.

Decomposition:
- Package uart_sched_pkg holds:
  - state enum {S_IDLE, S_XFER, S_GAP}
  - BYTE_W = 8
  - clog2-derived width localparams helper
- One sub-module, rr_arbiter:
  - Parameterised on N_REQ.
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant and encoded id.
  - Purely combinational: double-width mask-and-priority-encode.
- FSM, counters and muxing live in uart_tx_sched.

Test Plan:
- Single packet: requester 1 sends 3 bytes 0x55,0xAA,0x0F (last on 0x0F), tx_ready=1 → grant_id=1 one cycle after req_valid; tx_data sequence 55,AA,0F on 3 consecutive cycles; busy drops; 16-cycle GAP with tx_valid=0.
- Fairness: requesters 0,1,2,3 all hold 1-byte packets continuously → grant order 0,1,2,3,0,…; each grant separated by GAP_CYCLES+1 cycles; no requester granted twice before the other three.
- Backpressure: tx_ready toggles 1,0,0,1 during a 4-byte packet → no byte lost or duplicated; timeout_err stays 0; byte order preserved.
- Burst limit: MAX_BURST=4, requester 2 sends 10 bytes with no last → release after the 4th byte; requester 3 (waiting) is granted next; requester 2 resumes with byte 5 on a later grant.
- Timeout: TIMEOUT=8, requester 0 sends 1 byte without last, then req_valid=0 → timeout_err pulses exactly 8 cycles after the stall starts; busy=0; next requester is granted after the gap.
- Reset mid-packet: assert rst_n=0 during XFER of requester 3 → outputs 0 immediately (asynchronous); after release, a simultaneous request from 0 and 3 grants 0 first.
